// File: rtl/if_fetch_unit.sv
// MIPS IF stage with the IF/ID register: PC, imem request/ready handshake, one-word skid buffer, redirect squash.
// Build option IF_DELAY_SLOT_EN: branch delay slot (slot word kept, redirect target deferred until it is accepted).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_src,
  input  logic [31:0] Branch_target,
  input  logic [31:0] Jr_target,
  input  logic        ID_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_valid
);

  // state | meaning
  // FETCH | request outstanding at pc_q
  // HOLD  | returned word parked in skid_q while ID stalls, no request
  // DRAIN | squashed request still outstanding at stale_q, its reply is dropped
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] stale_q, stale_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        squash;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] accept_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = valid_q && !ID_stall && (PC_src != 2'b00);

  always_comb begin
    case (PC_src)
      2'b01:   target = Branch_target;
      2'b10:   target = {pc4_q[31:28], instr_q[25:0], 2'b00};
      default: target = Jr_target;
    endcase
  end

`ifdef IF_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        accepting;

  assign squash    = 1'b0;
  assign accept_pc = redirect ? target : (pend_q ? pend_pc_q : pc_plus4);
  assign accepting = !ID_stall && ((state_q == S_HOLD) || ((state_q == S_FETCH) && imem_ready));

  // The slot word may arrive after the branch leaves ID, so the target waits here.
  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (accepting) begin
      pend_d = 1'b0;
    end else if (redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end
`else
  assign squash    = redirect;
  assign accept_pc = pc_plus4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    stale_d = stale_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        if (squash) begin
          pc_d    = target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (!imem_ready) begin
            stale_d = pc_q;
            state_d = S_DRAIN;
          end
        end else if (imem_ready && ID_stall) begin
          skid_d  = imem_rdata;
          state_d = S_HOLD;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = accept_pc;
        end else if (!ID_stall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!ID_stall) begin
          state_d = S_FETCH;
          if (squash) begin
            pc_d    = target;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d = skid_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = accept_pc;
          end
        end
      end
      S_DRAIN: begin
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_WORD;
      stale_q <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      stale_q <= stale_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req       = (state_q != S_HOLD);
  assign imem_addr      = (state_q == S_DRAIN) ? stale_q : pc_q;
  assign ID_instruction = instr_q;
  assign ID_PC_plus4    = pc4_q;
  assign ID_valid       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand sequences, and randomized run against a queue model.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [1:0]  PC_src;
  logic [31:0] Branch_target;
  logic [31:0] Jr_target;
  logic        ID_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ID_instruction;
  logic [31:0] ID_PC_plus4;
  logic        ID_valid;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .PC_src(PC_src), .Branch_target(Branch_target),
    .Jr_target(Jr_target), .ID_stall(ID_stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ID_instruction(ID_instruction), .ID_PC_plus4(ID_PC_plus4), .ID_valid(ID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        ready;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[25];

  // Memory image: two planted words for the lw and j cases, a scrambled address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0008: mem_word = 32'h8C08_0004;
      32'h1000_0004: mem_word = 32'h0800_0040;
      default:       mem_word = {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endcase
  endfunction

  function automatic vec_t v(input logic st, input logic rd, input logic [1:0] s, input logic [31:0] t,
                             input logic rq, input logic [31:0] a, input logic vl,
                             input logic [31:0] ins, input logic [31:0] p4);
    v.stall = st; v.ready = rd; v.src = s; v.tgt = t;
    v.e_req = rq; v.e_addr = a; v.e_valid = vl; v.e_instr = ins; v.e_pc4 = p4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic obs(input string tag, input logic rq, input logic [31:0] a, input logic vl,
                     input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, rq});
    if (rq) chk({tag, ".addr"}, imem_addr, a);
    chk({tag, ".valid"}, {31'b0, ID_valid}, {31'b0, vl});
    chk({tag, ".instr"}, ID_instruction, ins);
    if (vl) chk({tag, ".pc4"}, ID_PC_plus4, p4);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [1:0] s, input logic [31:0] t);
    ID_stall      = st;
    imem_ready    = rd;
    PC_src        = s;
    Branch_target = t;
    Jr_target     = t;
    imem_rdata    = rd ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0);
    obs("reset", 1'b1, RST_PC, 1'b0, NOP, 32'h0);
    chk("reset.pc4_zero", ID_PC_plus4, 32'h0);
    reset = 1'b1;
  endtask

  // Reference model state: words returned but not yet in ID, in program order.
  logic [31:0] q[$];
  logic [31:0] deliver_pc, stale_addr, m_instr, m_pc4, ea;
  logic        discard, m_valid, er, got, redir;

  initial begin
    reset = 1'b0; PC_src = 2'b00; Branch_target = 32'h0; Jr_target = 32'h0;
    ID_stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

`ifndef IF_DELAY_SLOT_EN
    tbl[0]  = v(0, 1, 2'b00, 32'h0,         1, 32'h0040_0000, 0, NOP, 32'h0);
    tbl[1]  = v(0, 1, 2'b00, 32'h0,         1, 32'h0040_0004, 1, mem_word(32'h0040_0000), 32'h0040_0004);
    tbl[2]  = v(1, 1, 2'b00, 32'h0,         1, 32'h0040_0008, 1, mem_word(32'h0040_0004), 32'h0040_0008);
    tbl[3]  = v(1, 0, 2'b00, 32'h0,         0, 32'h0,         1, mem_word(32'h0040_0004), 32'h0040_0008);
    tbl[4]  = v(1, 0, 2'b00, 32'h0,         0, 32'h0,         1, mem_word(32'h0040_0004), 32'h0040_0008);
    tbl[5]  = v(0, 0, 2'b00, 32'h0,         0, 32'h0,         1, mem_word(32'h0040_0004), 32'h0040_0008);
    tbl[6]  = v(0, 0, 2'b00, 32'h0,         1, 32'h0040_000C, 1, 32'h8C08_0004, 32'h0040_000C);
    tbl[7]  = v(0, 1, 2'b00, 32'h0,         1, 32'h0040_000C, 0, NOP, 32'h0);
    tbl[8]  = v(0, 0, 2'b01, 32'h0000_0100, 1, 32'h0040_0010, 1, mem_word(32'h0040_000C), 32'h0040_0010);
    tbl[9]  = v(0, 0, 2'b00, 32'h0,         1, 32'h0040_0010, 0, NOP, 32'h0);
    tbl[10] = v(0, 0, 2'b00, 32'h0,         1, 32'h0040_0010, 0, NOP, 32'h0);
    tbl[11] = v(0, 1, 2'b00, 32'h0,         1, 32'h0040_0010, 0, NOP, 32'h0);
    tbl[12] = v(0, 1, 2'b00, 32'h0,         1, 32'h0000_0100, 0, NOP, 32'h0);
    tbl[13] = v(0, 1, 2'b00, 32'h0,         1, 32'h0000_0104, 1, mem_word(32'h0000_0100), 32'h0000_0104);
    tbl[14] = v(0, 1, 2'b11, 32'h0000_0200, 1, 32'h0000_0108, 1, mem_word(32'h0000_0104), 32'h0000_0108);
    tbl[15] = v(0, 1, 2'b00, 32'h0,         1, 32'h0000_0200, 0, NOP, 32'h0);
    tbl[16] = v(0, 1, 2'b11, 32'h1000_0004, 1, 32'h0000_0204, 1, mem_word(32'h0000_0200), 32'h0000_0204);
    tbl[17] = v(0, 1, 2'b00, 32'h0,         1, 32'h1000_0004, 0, NOP, 32'h0);
    tbl[18] = v(0, 1, 2'b10, 32'h0,         1, 32'h1000_0008, 1, 32'h0800_0040, 32'h1000_0008);
    tbl[19] = v(0, 1, 2'b00, 32'h0,         1, 32'h1000_0100, 0, NOP, 32'h0);
    tbl[20] = v(0, 1, 2'b11, 32'hFFFF_FFFC, 1, 32'h1000_0104, 1, mem_word(32'h1000_0100), 32'h1000_0104);
    tbl[21] = v(0, 1, 2'b00, 32'h0,         1, 32'hFFFF_FFFC, 0, NOP, 32'h0);
    tbl[22] = v(0, 1, 2'b00, 32'h0,         1, 32'h0000_0000, 1, mem_word(32'hFFFF_FFFC), 32'h0000_0000);
    tbl[23] = v(0, 0, 2'b00, 32'h0,         1, 32'h0000_0004, 1, mem_word(32'h0000_0000), 32'h0000_0004);
    tbl[24] = v(0, 0, 2'b00, 32'h0,         1, 32'h0000_0004, 0, NOP, 32'h0);

    for (int i = 0; i < 25; i++) begin
      obs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc4);
      drive(tbl[i].stall, tbl[i].ready, tbl[i].src, tbl[i].tgt);
    end

    // Reset while draining a squashed fetch abandons it.
    drive(0, 1, 2'b00, 32'h0);
    obs("drn_pre", 1'b1, 32'h0000_0008, 1'b1, mem_word(32'h0000_0004), 32'h0000_0008);
    drive(0, 0, 2'b01, 32'h0000_0040);
    obs("drn_stale", 1'b1, 32'h0000_0008, 1'b0, NOP, 32'h0);
    do_reset();
    drive(0, 1, 2'b00, 32'h0);
    obs("drn_after", 1'b1, 32'h0040_0004, 1'b1, mem_word(32'h0040_0000), 32'h0040_0004);

    // Randomized run against the queue model.
    do_reset();
    q.delete();
    deliver_pc = RST_PC; stale_addr = 32'h0; discard = 1'b0;
    m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      er = (q.size() == 0);
      ea = discard ? stale_addr : deliver_pc;
      obs("rnd", er, ea, m_valid, m_instr, m_pc4);
      ID_stall      = ($urandom_range(0, 3) == 0);
      imem_ready    = imem_req && ($urandom_range(0, 2) != 0);
      imem_rdata    = imem_ready ? mem_word(imem_addr) : $urandom;
      PC_src        = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      Branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      Jr_target     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);

      got   = er && imem_ready;
      redir = m_valid && !ID_stall && (PC_src != 2'b00);
      if (got) begin
        if (discard) discard = 1'b0;
        else q.push_back(mem_word(ea));
      end
      if (redir) begin
        case (PC_src)
          2'b01:   deliver_pc = Branch_target;
          2'b10:   deliver_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
          default: deliver_pc = Jr_target;
        endcase
        q.delete();
        m_valid = 1'b0;
        m_instr = NOP;
        if (er && !imem_ready) begin
          discard    = 1'b1;
          stale_addr = ea;
        end
      end else if (!ID_stall) begin
        if (q.size() != 0) begin
          m_instr    = q.pop_front();
          m_valid    = 1'b1;
          deliver_pc = deliver_pc + 32'd4;
          m_pc4      = deliver_pc;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
      @(posedge clk);
      #1;
    end
`else
    obs("ds0", 1'b1, 32'h0040_0000, 1'b0, NOP, 32'h0);
    drive(0, 1, 2'b00, 32'h0);
    obs("ds1", 1'b1, 32'h0040_0004, 1'b1, mem_word(32'h0040_0000), 32'h0040_0004);
    drive(0, 1, 2'b01, 32'h0000_0100);
    obs("ds_slot", 1'b1, 32'h0000_0100, 1'b1, mem_word(32'h0040_0004), 32'h0040_0008);
    drive(0, 1, 2'b00, 32'h0);
    obs("ds_tgt", 1'b1, 32'h0000_0104, 1'b1, mem_word(32'h0000_0100), 32'h0000_0104);
    drive(0, 0, 2'b01, 32'h0000_0300);
    obs("ds_bub", 1'b1, 32'h0000_0104, 1'b0, NOP, 32'h0);
    drive(0, 1, 2'b00, 32'h0);
    obs("ds_slot2", 1'b1, 32'h0000_0300, 1'b1, mem_word(32'h0000_0104), 32'h0000_0108);
    drive(0, 1, 2'b00, 32'h0);
    obs("ds_tgt2", 1'b1, 32'h0000_0304, 1'b1, mem_word(32'h0000_0300), 32'h0000_0304);
`endif

    // Reset with a fetch outstanding.
    drive(0, 0, 2'b00, 32'h0);
    do_reset();
    drive(0, 1, 2'b00, 32'h0);
    obs("post_rst", 1'b1, 32'h0040_0004, 1'b1, mem_word(32'h0040_0000), 32'h0040_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
